// File: rtl/usr_pkg.sv
//------------------------------------------------------------------------------
// Module  : usr_pkg
// Brief   : Opcode/state types and helpers for the parametrised universal
//           shift register.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package usr_pkg;

  typedef enum logic [2:0] {
    USR_NOP  = 3'd0,
    USR_SHL  = 3'd1,
    USR_SHR  = 3'd2,
    USR_LOAD = 3'd3,
    USR_ROL  = 3'd4,
    USR_ROR  = 3'd5,
    USR_ASR  = 3'd6,
    USR_RSVD = 3'd7
  } usr_op_t;

  typedef enum logic [0:0] {
    USR_IDLE  = 1'b0,
    USR_BURST = 1'b1
  } usr_state_t;

  // Only position-moving operations can be repeated by the burst engine.
  function automatic logic is_burst_op(input usr_op_t op);
    case (op)
      USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_ASR: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/usr_next_value.sv
//------------------------------------------------------------------------------
// Module  : usr_next_value
// Brief   : Combinational next-value function of the shift register, shared
//           by the single-operation and burst paths.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usr_next_value
  import usr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur_value,
  input  usr_op_t          op,
  input  logic             ser_left,
  input  logic             ser_right,
  input  logic [WIDTH-1:0] par_data,
  output logic [WIDTH-1:0] next_value
);

  always_comb begin
    next_value = cur_value;
    case (op)
      USR_SHL:  next_value = {cur_value[WIDTH-2:0], ser_right};
      USR_SHR:  next_value = {ser_left, cur_value[WIDTH-1:1]};
      USR_LOAD: next_value = par_data;
      USR_ROL:  next_value = {cur_value[WIDTH-2:0], cur_value[WIDTH-1]};
      USR_ROR:  next_value = {cur_value[0], cur_value[WIDTH-1:1]};
      USR_ASR:  next_value = {cur_value[WIDTH-1], cur_value[WIDTH-1:1]};
      default:  next_value = cur_value;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/universal_shift_register_param.sv
//------------------------------------------------------------------------------
// Module  : universal_shift_register_param
// Brief   : Parametrised universal shift register with rotate/arithmetic modes
//           and a Busy/Done burst engine repeating one shift N times.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module universal_shift_register_param
  import usr_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic [2:0]       USR_Operation_Select_In,
  input  logic             Start_In,
  input  logic [CNT_W-1:0] Shift_Count_In,
  input  logic             Serial_Left_Side_Data_In,
  input  logic             Serial_Right_Side_Data_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  output logic             Serial_Left_Side_Data_Out,
  output logic             Serial_Right_Side_Data_Out,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Busy_Out,
  output logic             Done_Out
);

  localparam logic [CNT_W-1:0] C_WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_ONE_CNT   = CNT_W'(1);

  usr_state_t       r_state, w_state_next;
  usr_op_t          r_op, w_op_next, w_op_live, w_op_apply;
  logic [CNT_W-1:0] r_count, w_count_next, w_count_sat;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             w_accept;

  assign w_op_live   = usr_op_t'(USR_Operation_Select_In);
  assign w_count_sat = (Shift_Count_In > C_WIDTH_CNT) ? C_WIDTH_CNT : Shift_Count_In;
  assign w_accept    = (r_state == USR_IDLE) && Start_In && is_burst_op(w_op_live);

  usr_next_value #(
    .WIDTH (WIDTH)
  ) u_next_value (
    .cur_value  (r_data),
    .op         (w_op_apply),
    .ser_left   (Serial_Left_Side_Data_In),
    .ser_right  (Serial_Right_Side_Data_In),
    .par_data   (Parallel_Data_In),
    .next_value (w_data_next)
  );

  // w_op_apply stays NOP whenever the register must hold (disabled or on the
  // burst accept edge), so the data register can load w_data_next unconditionally.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_count_next = r_count;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_op_apply   = USR_NOP;
    if (Enable_In) begin
      case (r_state)
        USR_IDLE: begin
          if (w_accept) begin
            w_op_next = w_op_live;
            if (w_count_sat == '0) begin
              w_done_next = 1'b1;
            end else begin
              w_count_next = w_count_sat;
              w_state_next = USR_BURST;
              w_busy_next  = 1'b1;
            end
          end else begin
            w_op_apply = w_op_live;
          end
        end
        USR_BURST: begin
          w_op_apply   = r_op;
          w_count_next = r_count - C_ONE_CNT;
          if (r_count == C_ONE_CNT) begin
            w_state_next = USR_IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end
        end
        default: w_state_next = USR_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= USR_IDLE;
      r_op    <= USR_NOP;
      r_count <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_count <= w_count_next;
      r_data  <= w_data_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign Parallel_Data_Out          = r_data;
  assign Serial_Left_Side_Data_Out  = r_data[WIDTH-1];
  assign Serial_Right_Side_Data_Out = r_data[0];
  assign Busy_Out                   = r_busy;
  assign Done_Out                   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register_param.sv
//------------------------------------------------------------------------------
// Module  : tb_universal_shift_register_param
// Brief   : Self-checking bench: WIDTH 16/8/32 instances driven in lockstep and
//           compared against a behavioural model, plus directed constant checks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_universal_shift_register_param;

  logic        clk = 1'b0;
  logic        rst, en, start, sl, sr;
  logic [2:0]  op;
  logic [4:0]  cnt16;
  logic [3:0]  cnt8;
  logic [5:0]  cnt32;
  logic [15:0] pd16, q16;
  logic [7:0]  pd8, q8;
  logic [31:0] pd32, q32;
  logic        slo16, sro16, busy16, done16;
  logic        slo8, sro8, busy8, done8;
  logic        slo32, sro32, busy32, done32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  universal_shift_register_param #(.WIDTH(16)) u_dut16 (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .USR_Operation_Select_In(op),
    .Start_In(start), .Shift_Count_In(cnt16), .Serial_Left_Side_Data_In(sl),
    .Serial_Right_Side_Data_In(sr), .Parallel_Data_In(pd16),
    .Serial_Left_Side_Data_Out(slo16), .Serial_Right_Side_Data_Out(sro16),
    .Parallel_Data_Out(q16), .Busy_Out(busy16), .Done_Out(done16));

  universal_shift_register_param #(.WIDTH(8)) u_dut8 (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .USR_Operation_Select_In(op),
    .Start_In(start), .Shift_Count_In(cnt8), .Serial_Left_Side_Data_In(sl),
    .Serial_Right_Side_Data_In(sr), .Parallel_Data_In(pd8),
    .Serial_Left_Side_Data_Out(slo8), .Serial_Right_Side_Data_Out(sro8),
    .Parallel_Data_Out(q8), .Busy_Out(busy8), .Done_Out(done8));

  universal_shift_register_param #(.WIDTH(32)) u_dut32 (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .USR_Operation_Select_In(op),
    .Start_In(start), .Shift_Count_In(cnt32), .Serial_Left_Side_Data_In(sl),
    .Serial_Right_Side_Data_In(sr), .Parallel_Data_In(pd32),
    .Serial_Left_Side_Data_Out(slo32), .Serial_Right_Side_Data_Out(sro32),
    .Parallel_Data_Out(q32), .Busy_Out(busy32), .Done_Out(done32));

  // Reference state per instance: index 0 = WIDTH 16, 1 = WIDTH 8, 2 = WIDTH 32.
  int              widths[3] = '{16, 8, 32};
  int              cnt_ws[3] = '{5, 4, 6};
  longint unsigned m_val[3];
  int              m_rem[3];
  int              m_op[3];
  bit              m_busy[3];
  bit              m_done[3];

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, want);
    end
  endtask

  function automatic longint unsigned width_mask(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic longint unsigned apply_op(input int w, input int o, input longint unsigned v,
                                               input bit l, input bit r, input longint unsigned p);
    longint unsigned msb = 64'd1 << (w - 1);
    case (o)
      1: return ((v << 1) | 64'(r)) & width_mask(w);
      2: return (v >> 1) | (l ? msb : 64'd0);
      3: return p & width_mask(w);
      4: return ((v << 1) | ((v & msb) != 0 ? 64'd1 : 64'd0)) & width_mask(w);
      5: return (v >> 1) | ((v & 64'd1) != 0 ? msb : 64'd0);
      6: return (v >> 1) | (v & msb);
      default: return v;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_val[i] = 0; m_rem[i] = 0; m_op[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit e, input int o, input bit s, input longint unsigned c,
                            input bit l, input bit r, input longint unsigned p);
    int              w  = widths[i];
    longint unsigned cc = c & width_mask(cnt_ws[i]);
    m_done[i] = 0;
    if (!e) return;
    if (m_busy[i]) begin
      m_val[i] = apply_op(w, m_op[i], m_val[i], l, r, p);
      m_rem[i]--;
      if (m_rem[i] == 0) begin
        m_busy[i] = 0;
        m_done[i] = 1;
      end
    end else if (s && (o == 1 || o == 2 || o == 4 || o == 5 || o == 6)) begin
      m_op[i] = o;
      if (cc > longint'(w)) cc = longint'(w);
      if (cc == 0) m_done[i] = 1;
      else begin
        m_busy[i] = 1;
        m_rem[i]  = int'(cc);
      end
    end else begin
      m_val[i] = apply_op(w, o, m_val[i], l, r, p);
    end
  endtask

  task automatic compare_inst(input int i, input logic [63:0] q, input logic b, input logic d,
                              input logic lo, input logic ro);
    int w = widths[i];
    check_value($sformatf("w%0d_data", w), q, m_val[i]);
    check_value($sformatf("w%0d_busy", w), 64'(b), 64'(m_busy[i]));
    check_value($sformatf("w%0d_done", w), 64'(d), 64'(m_done[i]));
    check_value($sformatf("w%0d_serl", w), 64'(lo), (m_val[i] >> (w - 1)) & 64'd1);
    check_value($sformatf("w%0d_serr", w), 64'(ro), m_val[i] & 64'd1);
  endtask

  task automatic compare_all();
    compare_inst(0, 64'(q16), busy16, done16, slo16, sro16);
    compare_inst(1, 64'(q8),  busy8,  done8,  slo8,  sro8);
    compare_inst(2, 64'(q32), busy32, done32, slo32, sro32);
  endtask

  task automatic do_cycle(input bit e, input logic [2:0] o, input bit s, input logic [5:0] c,
                          input bit l, input bit r, input logic [63:0] p);
    en = e; op = o; start = s; sl = l; sr = r;
    cnt16 = c[4:0]; cnt8 = c[3:0]; cnt32 = c;
    pd16 = p[15:0]; pd8 = p[7:0]; pd32 = p[31:0];
    for (int i = 0; i < 3; i++) model_step(i, e, int'(o), s, 64'(c), l, r, p);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asserts reset between edges so the asynchronous clear is observed before any clock.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_value("async_rst_data", 64'(q16), 64'd0);
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = 3'd0; start = 1'b0; sl = 1'b0; sr = 1'b0;
    cnt16 = '0; cnt8 = '0; cnt32 = '0; pd16 = '0; pd8 = '0; pd32 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_data", 64'(q16), 64'd0);
    check_value("reset_busy", 64'(busy16), 64'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Load, then an asynchronous mid-cycle reset, then the reference load.
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'h1234);
    check_value("load_1234", 64'(q16), 64'h1234);
    apply_reset();
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'hA5C3);
    check_value("load_a5c3", 64'(q16), 64'hA5C3);
    check_value("load_serl", 64'(slo16), 64'd1);
    check_value("load_serr", 64'(sro16), 64'd1);

    // Single operations from 0x8001.
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'h8001);
    do_cycle(1, 3'd1, 0, 0, 0, 0, 64'h0);
    check_value("shl", 64'(q16), 64'h0002);
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'h8001);
    do_cycle(1, 3'd5, 0, 0, 0, 0, 64'h0);
    check_value("ror", 64'(q16), 64'hC000);
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'h8001);
    do_cycle(1, 3'd6, 0, 0, 0, 0, 64'h0);
    check_value("asr", 64'(q16), 64'hC000);
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'h8001);
    do_cycle(1, 3'd2, 0, 0, 0, 0, 64'h0);
    check_value("shr", 64'(q16), 64'h4000);
    do_cycle(1, 3'd7, 0, 0, 1, 1, 64'hFFFF);
    check_value("rsvd_hold", 64'(q16), 64'h4000);

    // Burst ROL x4; opcode and parallel data churn during the burst.
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'h0001);
    do_cycle(1, 3'd4, 1, 6'd4, 0, 0, 64'h0);
    check_value("rol_accept_busy", 64'(busy16), 64'd1);
    check_value("rol_accept_data", 64'(q16), 64'h0001);
    for (int k = 1; k <= 4; k++) begin
      do_cycle(1, 3'(k % 4 + 1) | 3'd2, 1, 6'd3, 1, 1, 64'hFFFF);
      check_value("rol_busy", 64'(busy16), (k < 4) ? 64'd1 : 64'd0);
      check_value("rol_done", 64'(done16), (k == 4) ? 64'd1 : 64'd0);
    end
    check_value("rol_final", 64'(q16), 64'h0010);
    do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);
    check_value("rol_done_clear", 64'(done16), 64'd0);

    // Count zero: immediate Done, no Busy.
    do_cycle(1, 3'd4, 1, 6'd0, 0, 0, 64'h0);
    check_value("cnt0_done", 64'(done16), 64'd1);
    check_value("cnt0_busy", 64'(busy16), 64'd0);
    check_value("cnt0_data", 64'(q16), 64'h0010);
    do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);
    check_value("cnt0_done_clear", 64'(done16), 64'd0);

    // Count 31 saturates to WIDTH.
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'hFFFF);
    do_cycle(1, 3'd1, 1, 6'd31, 0, 0, 64'h0);
    for (int k = 1; k <= 16; k++) begin
      do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);
      check_value("sat_done", 64'(done16), (k == 16) ? 64'd1 : 64'd0);
    end
    check_value("sat_final", 64'(q16), 64'h0000);
    repeat (20) do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);

    // Enable dropped mid-burst freezes everything.
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'hFF00);
    do_cycle(1, 3'd2, 1, 6'd8, 0, 0, 64'h0);
    repeat (4) do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 3'd4, 1, 6'd2, 1, 1, 64'h0);
      check_value("en_freeze_data", 64'(q16), 64'h0FF0);
      check_value("en_freeze_busy", 64'(busy16), 64'd1);
    end
    repeat (4) do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);
    check_value("en_final", 64'(q16), 64'h00FF);
    check_value("en_done", 64'(done16), 64'd1);

    // Reset mid-burst aborts without Done.
    do_cycle(1, 3'd3, 0, 0, 0, 0, 64'hFF00);
    do_cycle(1, 3'd2, 1, 6'd8, 0, 0, 64'h0);
    repeat (3) do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);
    apply_reset();
    repeat (2) begin
      do_cycle(1, 3'd0, 0, 0, 0, 0, 64'h0);
      check_value("rst_burst_done", 64'(done16), 64'd0);
      check_value("rst_burst_data", 64'(q16), 64'd0);
    end

    // Randomised scoreboard across all three widths.
    for (int k = 0; k < 200; k++) begin
      do_cycle(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
               6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
